// File: rtl/whack_judge_pkg.sv
// Shared whack-a-mole definitions: judge state encodings and hole constants,
// also used by the position generator and the display.
package whack_judge_pkg;

    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_HIT   = 2'd1,
        ST_MISS  = 2'd2,
        ST_OVER  = 2'd3
    } judge_state_t;

    localparam int         NUM_HOLES_DFLT = 5;
    localparam logic [2:0] NO_MOLE        = 3'd5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registers the debounced hole buttons and reports rising edges. Resets to all
// ones so a button held through reset does not count as a fresh press.
module btn_edge_detect #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_level,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] level_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) level_q <= '1;
        else       level_q <= i_level;
    end

    assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/whack_judge.sv
// Judges hole-button presses against the current mole position and keeps score.
// Optional build macro ESCAPE_PENALTY_EN: a mole moving away unpressed in ARMED counts as a miss.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_ARMED | waiting for a press; every press edge is judged hit or miss
// ST_HIT   | hit flash for FLASH_CYCLES clocks, presses discarded
// ST_MISS  | miss lockout for LOCKOUT_CYCLES clocks, presses discarded
// ST_OVER  | miss limit reached; terminal until reset
module whack_judge
    import whack_judge_pkg::*;
#(
    parameter int NUM_HOLES      = NUM_HOLES_DFLT,
    parameter int SCORE_W        = 8,
    parameter int MISS_W         = 4,
    parameter int MAX_MISSES     = 3,
    parameter int FLASH_CYCLES   = 4,
    parameter int LOCKOUT_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [2:0]           i_mole_position,
    input  logic [NUM_HOLES-1:0] i_buttons,
    output logic                 o_change_position,
    output logic [SCORE_W-1:0]   o_score,
    output logic [MISS_W-1:0]    o_misses,
    output logic                 o_hit_flash,
    output logic                 o_miss_flash,
    output logic                 o_game_over
);

    localparam int TIMER_MAX = max_int(FLASH_CYCLES, LOCKOUT_CYCLES);
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] FLASH_TC   = TIMER_W'(FLASH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_TC = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]         HOLE_LIMIT = 3'(NUM_HOLES);
    localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);

    judge_state_t         state;
    logic [2:0]           pos_q;
    logic [TIMER_W-1:0]   timer;
    logic [NUM_HOLES-1:0] press;
    logic [NUM_HOLES-1:0] pos_mask;
    logic                 mole_up;
    logic                 press_any;
    logic                 press_hit;
    logic                 escape;
    logic [MISS_W-1:0]    misses_inc;

    btn_edge_detect #(.W(NUM_HOLES)) u_btn_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_level (i_buttons),
        .o_rise  (press)
    );

    // A single press edge exactly on the registered mole hole is the only hit.
    assign mole_up    = (pos_q < HOLE_LIMIT);
    assign pos_mask   = NUM_HOLES'(1) << pos_q;
    assign press_any  = |press;
    assign press_hit  = mole_up && (press == pos_mask);
    assign misses_inc = o_misses + MISS_W'(1);

`ifdef ESCAPE_PENALTY_EN
    assign escape = !press_any && mole_up && (i_mole_position != pos_q);
`else
    assign escape = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= ST_ARMED;
            pos_q             <= HOLE_LIMIT;
            timer             <= '0;
            o_change_position <= 1'b0;
            o_score           <= '0;
            o_misses          <= '0;
            o_hit_flash       <= 1'b0;
            o_miss_flash      <= 1'b0;
            o_game_over       <= 1'b0;
        end else begin
            pos_q             <= i_mole_position;
            o_change_position <= 1'b0;
            case (state)
                ST_ARMED: begin
                    if (press_hit) begin
                        if (o_score != '1) o_score <= o_score + SCORE_W'(1);
                        o_change_position <= 1'b1;
                        o_hit_flash       <= 1'b1;
                        timer             <= '0;
                        state             <= ST_HIT;
                    end else if (press_any || escape) begin
                        o_misses <= misses_inc;
                        timer    <= '0;
                        if (misses_inc == MISS_LIMIT) begin
                            o_game_over <= 1'b1;
                            state       <= ST_OVER;
                        end else begin
                            o_miss_flash <= 1'b1;
                            state        <= ST_MISS;
                        end
                    end
                end
                ST_HIT: begin
                    if (timer == FLASH_TC) begin
                        o_hit_flash <= 1'b0;
                        state       <= ST_ARMED;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_MISS: begin
                    if (timer == LOCKOUT_TC) begin
                        o_miss_flash <= 1'b0;
                        state        <= ST_ARMED;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_OVER: begin
                    o_game_over <= 1'b1;
                end
                default: state <= ST_ARMED;
            endcase
        end
    end

endmodule
